// File: rtl/lea128_key_schedule_pkg.sv
// Shared constants, types and helpers for the LEA-128 round-key schedule (package lea_pkg).
package lea_pkg;

  localparam int WORD_W_128     = 32;
  localparam int NUM_ROUNDS_128 = 24;

  localparam int ROT_T0 = 1;
  localparam int ROT_T1 = 3;
  localparam int ROT_T2 = 6;
  localparam int ROT_T3 = 11;

  typedef logic [31:0]    rk_word_t;
  typedef rk_word_t [5:0] round_key_t;
  typedef rk_word_t [3:0] ks_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } ks_fsm_t;

  localparam rk_word_t LEA_DELTA [0:3] = '{
    32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec
  };

  function automatic rk_word_t rol32(input rk_word_t x, input logic [4:0] sh);
    logic [63:0] dbl;
    dbl = {x, x} << sh;
    return dbl[63:32];
  endfunction

  // Round-key word order seen by the round datapath: {T0,T1,T2,T1,T3,T1} from word 0 up.
  function automatic round_key_t pack_rk(input ks_state_t t);
    return {t[1], t[3], t[1], t[2], t[1], t[0]};
  endfunction

endpackage

// File: rtl/lea128_key_schedule_if.sv
// Start/key request and round-key valid/ready handshake of the LEA-128 key schedule.
interface lea128_key_schedule_if;
  import lea_pkg::*;

  logic         Start;
  logic [127:0] Key;
  logic         Busy;
  logic         RkValid;
  logic         RkReady;
  round_key_t   RoundKey;
  logic [4:0]   RoundIdx;
  logic         Done;

  modport master (
    output Start, Key, RkReady,
    input  Busy, RkValid, RoundKey, RoundIdx, Done
  );

  modport slave (
    input  Start, Key, RkReady,
    output Busy, RkValid, RoundKey, RoundIdx, Done
  );

endinterface

// File: rtl/lea128_key_schedule_step.sv
// One LEA-128 key-schedule step (module lea_ks_step): delta select plus four add/rotate lanes.
module lea_ks_step
  import lea_pkg::*;
(
  input  ks_state_t  t_in,
  input  logic [4:0] step_idx,
  output ks_state_t  t_out
);

  rk_word_t delta_s;

  // Each lane adds delta rotated by (step + lane) mod 32, then applies its fixed rotate.
  always_comb begin
    delta_s  = LEA_DELTA[step_idx[1:0]];
    t_out[0] = rol32(t_in[0] + rol32(delta_s, step_idx),         5'(ROT_T0));
    t_out[1] = rol32(t_in[1] + rol32(delta_s, step_idx + 5'd1),  5'(ROT_T1));
    t_out[2] = rol32(t_in[2] + rol32(delta_s, step_idx + 5'd2),  5'(ROT_T2));
    t_out[3] = rol32(t_in[3] + rol32(delta_s, step_idx + 5'd3),  5'(ROT_T3));
  end

endmodule

// File: rtl/lea128_key_schedule.sv
// LEA-128 round-key generator: one 192-bit round key per valid/ready handshake.
// Optional macro LEA_KS_ZEROIZE_EN clears the key-derived state once RK_23 is consumed.
module lea128_key_schedule
  import lea_pkg::*;
#(
  parameter int NUM_ROUNDS = 24,
  parameter int WORD_W     = 32
) (
  input logic                  CLK,
  input logic                  RSTn,
  lea128_key_schedule_if.slave bus
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_ROUNDS - 1);

  if (NUM_ROUNDS != NUM_ROUNDS_128 || WORD_W != WORD_W_128) begin : g_bad_cfg
    $error("lea128_key_schedule: NUM_ROUNDS must be 24 and WORD_W must be 32");
  end

  ks_fsm_t    state_q, state_d;
  ks_state_t  t_q, t_d;
  round_key_t rk_q, rk_d;
  logic [4:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  ks_state_t  step_in_s;
  ks_state_t  step_out_s;
  logic [4:0] step_idx_s;

  // In IDLE the step consumes the master key directly; otherwise it advances the held T.
  always_comb begin
    if (state_q == IDLE) begin
      step_in_s  = bus.Key;
      step_idx_s = 5'd0;
    end else begin
      step_in_s  = t_q;
      step_idx_s = idx_q + 5'd1;
    end
  end

  lea_ks_step u_step (
    .t_in     (step_in_s),
    .step_idx (step_idx_s),
    .t_out    (step_out_s)
  );

  // Next-state and next-output logic of the schedule FSM.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          t_d     = step_out_s;
          rk_d    = pack_rk(step_out_s);
          idx_d   = 5'd0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = GEN;
        end else begin
          state_d = IDLE;
        end
      end
      GEN: begin
        if (valid_q && bus.RkReady) begin
          if (idx_q < LAST_IDX) begin
            t_d   = step_out_s;
            rk_d  = pack_rk(step_out_s);
            idx_d = idx_q + 5'd1;
          end else begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
`ifdef LEA_KS_ZEROIZE_EN
            t_d   = '0;
            rk_d  = '0;
            idx_d = 5'd0;
`else
            t_d   = t_q;
            rk_d  = rk_q;
            idx_d = idx_q;
`endif
          end
        end else begin
          state_d = GEN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any schedule in progress.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      t_q     <= '0;
      rk_q    <= '0;
      idx_q   <= 5'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.RoundKey = rk_q;
  assign bus.RoundIdx = idx_q;
  assign bus.RkValid  = valid_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;

endmodule

// File: tb/tb_lea128_key_schedule.sv
// Self-checking bench for lea128_key_schedule with a queue-based round-key scoreboard.
module tb_lea128_key_schedule;

  logic CLK = 1'b0;
  logic RSTn;

  lea128_key_schedule_if bus ();

  lea128_key_schedule #(.NUM_ROUNDS(24), .WORD_W(32)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0]   idx;
    logic [191:0] rk;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  localparam logic [127:0] KISA_KEY = {32'hf0e1d2c3, 32'hb4a59687, 32'h78695a4b, 32'h3c2d1e0f};

  function automatic logic [31:0] m_rol(input logic [31:0] x, input int n);
    int s;
    s = n % 32;
    if (s == 0) return x;
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [31:0] m_delta(input int i);
    case (i % 4)
      0:       return 32'hc3efe9db;
      1:       return 32'h44626b02;
      2:       return 32'h79e27c8a;
      default: return 32'h78df30ec;
    endcase
  endfunction

  // Golden model: pushes RK_0..RK_23 of the given master key onto the scoreboard.
  task automatic push_sched(input logic [127:0] key);
    logic [31:0] a, b, c, d, dl;
    exp_t e;
    a = key[31:0];
    b = key[63:32];
    c = key[95:64];
    d = key[127:96];
    for (int i = 0; i < 24; i++) begin
      dl = m_delta(i);
      a = m_rol(a + m_rol(dl, i), 1);
      b = m_rol(b + m_rol(dl, i + 1), 3);
      c = m_rol(c + m_rol(dl, i + 2), 6);
      d = m_rol(d + m_rol(dl, i + 3), 11);
      e.idx = 5'(i);
      e.rk  = {b, d, b, c, b, a};
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    bus.Start   = 1'b0;
    bus.Key     = '0;
    bus.RkReady = 1'b0;
    RSTn        = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_vec++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
    n_vec++; if (bus.RkValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.RkValid); end
    n_vec++; if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.Done); end
    n_vec++; if (bus.RoundIdx !== 5'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", bus.RoundIdx); end
    n_vec++; if (bus.RoundKey !== 192'd0) begin n_fail++; $display("FAIL reset_rk: got %h expected 0", bus.RoundKey); end
    RSTn        = 1'b1;
    bus.RkReady = 1'b1;
    @(posedge CLK); #1;
    n_vec++; if (bus.RkValid !== 1'b0) begin n_fail++; $display("FAIL idle_ready_ignored: got valid %b expected 0", bus.RkValid); end
  endtask

  task automatic test_zero_key();
    logic [191:0] exp_rk;
    bit done_seen;
    done_seen = 1'b0;
    exp_rk = {32'h3efe9dbc, 32'hfa76f0fb, 32'h3efe9dbc, 32'hefe9dbc3, 32'h3efe9dbc, 32'h87dfd3b7};
    bus.Key = '0; bus.RkReady = 1'b1; bus.Start = 1'b1;
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    n_vec++; if (bus.RkValid !== 1'b1 || bus.RoundIdx !== 5'd0) begin
      n_fail++; $display("FAIL zero_first: got valid %b idx %0d expected valid 1 idx 0", bus.RkValid, bus.RoundIdx);
    end
    n_vec++; if (bus.RoundKey !== exp_rk) begin n_fail++; $display("FAIL zero_rk0: got %h expected %h", bus.RoundKey, exp_rk); end
    for (int c = 0; c < 40 && !done_seen; c++) begin
      @(posedge CLK); #1;
      done_seen = (bus.Done === 1'b1);
    end
    n_vec++; if (!done_seen) begin n_fail++; $display("FAIL zero_done: got no Done expected Done within 40 cycles"); end
    @(posedge CLK); #1;
  endtask

  task automatic test_kisa();
    exp_t e;
    logic [191:0] last_rk;
    exp_q.delete();
    push_sched(KISA_KEY);
    last_rk = exp_q[23].rk;
    bus.Key = KISA_KEY; bus.RkReady = 1'b1; bus.Start = 1'b1;
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    bus.Key   = ~KISA_KEY;
    for (int cyc = 1; cyc <= 26; cyc++) begin
      if (cyc <= 24) begin
        n_vec++; if (bus.Busy !== 1'b1 || bus.RkValid !== 1'b1 || bus.Done !== 1'b0) begin
          n_fail++; $display("FAIL kisa_flags c%0d: got busy %b valid %b done %b expected 1 1 0", cyc, bus.Busy, bus.RkValid, bus.Done);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_vec++; if (bus.RoundIdx !== e.idx || bus.RoundKey !== e.rk) begin
            n_fail++; $display("FAIL kisa_rk c%0d: got idx %0d rk %h expected idx %0d rk %h", cyc, bus.RoundIdx, bus.RoundKey, e.idx, e.rk);
          end
        end
      end else if (cyc == 25) begin
        n_vec++; if (bus.Done !== 1'b1 || bus.Busy !== 1'b0 || bus.RkValid !== 1'b0) begin
          n_fail++; $display("FAIL kisa_done_t25: got done %b busy %b valid %b expected 1 0 0", bus.Done, bus.Busy, bus.RkValid);
        end
      end else begin
        n_vec++; if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL kisa_done_pulse: got %b expected 0", bus.Done); end
      end
      @(posedge CLK); #1;
    end
`ifdef LEA_KS_ZEROIZE_EN
    n_vec++; if (bus.RoundIdx !== 5'd0 || bus.RoundKey !== 192'd0) begin
      n_fail++; $display("FAIL kisa_hold: got idx %0d rk %h expected idx 0 rk 0", bus.RoundIdx, bus.RoundKey);
    end
`else
    n_vec++; if (bus.RoundIdx !== 5'd23 || bus.RoundKey !== last_rk) begin
      n_fail++; $display("FAIL kisa_hold: got idx %0d rk %h expected idx 23 rk %h", bus.RoundIdx, bus.RoundKey, last_rk);
    end
`endif
  endtask

  task automatic test_random_ready();
    logic [127:0] key;
    logic [191:0] prev_rk;
    logic [4:0]   prev_idx;
    bit stalled, done_seen;
    int hs;
    stalled = 1'b0; done_seen = 1'b0; hs = 0; prev_rk = '0; prev_idx = '0;
    key = {$urandom, $urandom, $urandom, $urandom};
    exp_q.delete();
    push_sched(key);
    bus.Key = key; bus.Start = 1'b1; bus.RkReady = 1'b0;
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    for (int c = 0; c < 400 && !done_seen; c++) begin
      if (bus.Done === 1'b1) begin
        done_seen = 1'b1;
      end else if (bus.RkValid === 1'b1) begin
        if (stalled) begin
          n_vec++; if (bus.RoundIdx !== prev_idx || bus.RoundKey !== prev_rk) begin
            n_fail++; $display("FAIL stall_stable: got idx %0d rk %h expected idx %0d rk %h", bus.RoundIdx, bus.RoundKey, prev_idx, prev_rk);
          end
        end
        if (exp_q.size() > 0) begin
          n_vec++; if (bus.RoundIdx !== exp_q[0].idx || bus.RoundKey !== exp_q[0].rk) begin
            n_fail++; $display("FAIL rand_rk: got idx %0d rk %h expected idx %0d rk %h", bus.RoundIdx, bus.RoundKey, exp_q[0].idx, exp_q[0].rk);
          end
        end
        bus.RkReady = 1'($urandom_range(0, 1));
        if (bus.RkReady) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          hs++;
          stalled = 1'b0;
        end else begin
          stalled  = 1'b1;
          prev_idx = bus.RoundIdx;
          prev_rk  = bus.RoundKey;
        end
      end else begin
        bus.RkReady = 1'($urandom_range(0, 1));
      end
      @(posedge CLK); #1;
    end
    n_vec++; if (!done_seen || hs != 24) begin
      n_fail++; $display("FAIL rand_handshakes: got done %b handshakes %0d expected done 1 handshakes 24", done_seen, hs);
    end
    bus.RkReady = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_start_during_gen();
    exp_t e;
    bit done_seen;
    int got;
    done_seen = 1'b0; got = 0;
    exp_q.delete();
    push_sched(KISA_KEY);
    bus.Key = KISA_KEY; bus.RkReady = 1'b1; bus.Start = 1'b1;
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      bus.Start = 1'b0;
      if (bus.Done === 1'b1) begin
        done_seen = 1'b1;
      end else if (bus.RkValid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got++;
        n_vec++; if (bus.RoundIdx !== e.idx || bus.RoundKey !== e.rk) begin
          n_fail++; $display("FAIL gen_start_rk: got idx %0d rk %h expected idx %0d rk %h", bus.RoundIdx, bus.RoundKey, e.idx, e.rk);
        end
        if (bus.RoundIdx === 5'd7) begin
          bus.Start = 1'b1;
          bus.Key   = 128'h0123456789abcdef_fedcba9876543210;
        end
      end
      @(posedge CLK); #1;
    end
    bus.Start = 1'b0;
    n_vec++; if (!done_seen || got != 24) begin
      n_fail++; $display("FAIL gen_start_count: got done %b keys %0d expected done 1 keys 24", done_seen, got);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid();
    bit hit, done_seen;
    hit = 1'b0; done_seen = 1'b0;
    bus.Key = {$urandom, $urandom, $urandom, $urandom};
    bus.RkReady = 1'b1; bus.Start = 1'b1;
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (bus.RoundIdx === 5'd12 && bus.RkValid === 1'b1) hit = 1'b1;
      else begin @(posedge CLK); #1; end
    end
    n_vec++; if (!hit) begin n_fail++; $display("FAIL rst_reach12: got idx %0d expected to reach 12", bus.RoundIdx); end
    #1;
    RSTn = 1'b0;
    #1;
    n_vec++; if (bus.Busy !== 1'b0 || bus.RkValid !== 1'b0 || bus.Done !== 1'b0 || bus.RoundIdx !== 5'd0 || bus.RoundKey !== 192'd0) begin
      n_fail++; $display("FAIL rst_async: got busy %b valid %b done %b idx %0d rk %h expected all 0", bus.Busy, bus.RkValid, bus.Done, bus.RoundIdx, bus.RoundKey);
    end
    @(posedge CLK); #1;
    RSTn = 1'b1;
    exp_q.delete();
    push_sched(KISA_KEY);
    bus.Key = KISA_KEY; bus.Start = 1'b1;
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    n_vec++; if (bus.RkValid !== 1'b1 || bus.RoundIdx !== 5'd0 || bus.RoundKey !== exp_q[0].rk) begin
      n_fail++; $display("FAIL rst_restart: got valid %b idx %0d rk %h expected valid 1 idx 0 rk %h", bus.RkValid, bus.RoundIdx, bus.RoundKey, exp_q[0].rk);
    end
    for (int c = 0; c < 40 && !done_seen; c++) begin
      @(posedge CLK); #1;
      done_seen = (bus.Done === 1'b1);
    end
    n_vec++; if (!done_seen) begin n_fail++; $display("FAIL rst_drain: got no Done expected Done within 40 cycles"); end
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back();
    bit done_seen;
    done_seen = 1'b0;
    exp_q.delete();
    push_sched(KISA_KEY);
    bus.Key = '0; bus.RkReady = 1'b1; bus.Start = 1'b1;
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      @(posedge CLK); #1;
      done_seen = (bus.Done === 1'b1);
    end
    n_vec++; if (!done_seen) begin n_fail++; $display("FAIL b2b_done: got no Done expected Done within 40 cycles"); end
    bus.Key = KISA_KEY; bus.Start = 1'b1;
    @(posedge CLK); #1;
    n_vec++; if (bus.RkValid !== 1'b0 || bus.Busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_start_on_done: got valid %b busy %b expected 0 0", bus.RkValid, bus.Busy);
    end
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    n_vec++; if (bus.RkValid !== 1'b1 || bus.RoundIdx !== 5'd0 || bus.RoundKey !== exp_q[0].rk) begin
      n_fail++; $display("FAIL b2b_restart: got valid %b idx %0d rk %h expected valid 1 idx 0 rk %h", bus.RkValid, bus.RoundIdx, bus.RoundKey, exp_q[0].rk);
    end
    done_seen = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      @(posedge CLK); #1;
      done_seen = (bus.Done === 1'b1);
    end
    n_vec++; if (!done_seen) begin n_fail++; $display("FAIL b2b_drain: got no Done expected Done within 40 cycles"); end
    @(posedge CLK); #1;
  endtask

  initial begin
    test_reset();
    test_zero_key();
    test_kisa();
    test_random_ready();
    test_start_during_gen();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
